fs_dither_stream: RTL
=====================

FS_DITHER_STREAM -- requirements
Module: fs_dither_stream

Interface
REQ-001 SHALL have parameter IMAGEX, default 64, meaning pixels per row (≥2).
REQ-002 SHALL have parameter IMAGEY, default 64, meaning rows per frame (≥2).
REQ-003 SHALL have parameter PIX_W, default 8, meaning input pixel width.
REQ-004 SHALL have parameter OUT_W, default 1, meaning output level width (1..PIX_W); the palette is 2^OUT_W levels.
REQ-005 SHALL have port clk, input, 1, the single clock for all logic.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port in_valid, input, 1, input pixel valid.
REQ-008 SHALL have port in_ready, output, 1, block accepts input.
REQ-009 SHALL have port in_pixel, input, PIX_W, unsigned pixel in raster order.
REQ-010 SHALL have port in_sof, input, 1, marks the accepted pixel as frame start (0,0).
REQ-011 SHALL have port cfg_mode, input, 1, selecting 0 = threshold only or 1 = Floyd-Steinberg.
REQ-012 SHALL have port out_valid, output, 1, output valid.
REQ-013 SHALL have port out_ready, input, 1, downstream accepts output.
REQ-014 SHALL have port out_level, output, OUT_W, quantised level.
REQ-015 SHALL have port out_eol, output, 1, qualifying out_level as last pixel of a row.
REQ-016 SHALL have port out_eof, output, 1, qualifying out_level as last pixel of a frame.
REQ-017 SHALL have port sync_err, output, 1, a one-cycle pulse on in_sof mismatch.

Function
REQ-018 Input SHALL be accepted on in_valid && in_ready; in_ready = !out_valid || out_ready.
REQ-019 Output SHALL register one cycle after acceptance; throughput SHALL be one pixel/cycle with out_ready high.
REQ-020 out_level/out_eol/out_eof SHALL hold stable while out_valid && !out_ready.
REQ-021 Internal x,y counters SHALL advance per accepted pixel; x wraps at IMAGEX-1, y at IMAGEY-1, and the frame wraps to (0,0).
REQ-022 cfg_mode SHALL be sampled only on acceptance of pixel (0,0) and held for the frame.
REQ-023 Corrected value v = in_pixel + fwd + row_err[x], as signed PIX_W+3; v_c = v clamped to [0, 2^PIX_W-1].
REQ-024 level = v_c >> (PIX_W-OUT_W); recon = level bit-replicated to PIX_W; e = v_c - recon (signed PIX_W+1).
REQ-025 Diffusion terms SHALL be computed separately with floor (arithmetic shift): R=(7e)>>>4, SW=(3e)>>>4, S=(5e)>>>4, SE=(1e)>>>4.
REQ-026 fwd for pixel x+1 SHALL be R of pixel x; fwd = 0 at x=0.
REQ-027 SW SHALL be dropped at x=0; R and SE SHALL be dropped at x=IMAGEX-1; SW/S/SE SHALL be dropped on row IMAGEY-1.
REQ-028 Row 0 SHALL use zero row_err; next-row error storage SHALL use first-touch overwrite, so no clear cycles are needed between rows or frames.
REQ-029 In mode 0, fwd and row_err SHALL be forced to 0 (v_c = in_pixel).
REQ-030 If in_sof is accepted while counters ≠ (0,0), sync_err SHALL pulse one cycle, the pixel SHALL be processed as (0,0), and all carried error SHALL be discarded.
REQ-031 in_sof at counters = (0,0) SHALL have no effect.

Reset
REQ-032 On rst_n low: out_valid=0, out_level=0, out_eol=0, out_eof=0, sync_err=0, counters=(0,0), fwd=0, mode=0; in_ready=1 after reset.
REQ-033 Reset asserted mid-frame SHALL discard the in-flight output; the first pixel after release is (0,0) with zero error.

Verification
REQ-034 Reset, then idle -> out_valid=0, in_ready=1, out_level=0.
REQ-035 mode 0, OUT_W=1, pixels 127,128 -> out_level 0,1, with no error carried.
REQ-036 mode 1, OUT_W=1, row 0 pixels 100,100 -> out 0 (e=100, R=43), then v=143 -> out 1 (e=-112).
REQ-037 IMAGEX=4, mode 1, row 0 = 100,0,0,0; row 1 x0 = 100 -> v=100+31+8=139, out 1; row 0 x3 R is not applied to row 1 x0.
REQ-038 out_ready low for 3 cycles mid-row -> out_level stable, in_ready=0, no pixel lost or duplicated; totals IMAGEX*IMAGEY outputs with a single out_eof.
REQ-039 in_sof at pixel (2,1) -> sync_err one-cycle pulse, out_eol after IMAGEX-1 further outputs, out_eof exactly IMAGEX*IMAGEY outputs after the sof pixel.

Source files
------------

// File: rtl/fs_dither_stream.sv
// Streaming Floyd-Steinberg (or plain threshold) quantiser, one pixel/cycle, output registered 1 cycle after accept.
// Backpressure: in_ready = !out_valid || out_ready; the output register holds while stalled.
module fs_dither_stream #(
    parameter int IMAGEX = 64,
    parameter int IMAGEY = 64,
    parameter int PIX_W  = 8,
    parameter int OUT_W  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_pixel,
    input  logic             in_sof,
    input  logic             cfg_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_level,
    output logic             out_eol,
    output logic             out_eof,
    output logic             sync_err
);
    localparam int XW = $clog2(IMAGEX);
    localparam int YW = $clog2(IMAGEY);
    localparam int VW = PIX_W + 3;

    typedef logic signed [VW-1:0] err_t;
    localparam err_t VMAX = err_t'((1 << PIX_W) - 1);

    logic [XW-1:0]    x_cnt, ex;
    logic [YW-1:0]    y_cnt, ey;
    logic             accept, last_col, last_row, at_origin, mode_q, mode_eff;
    err_t             fwd_q, se_prev, acc_prev;
    err_t             row_rd, fwd_use, v, e, p3, p5, p7;
    err_t             t_r, t_sw, t_s, t_se, acc_nxt;
    logic [PIX_W-1:0] v_c, recon;
    logic [OUT_W-1:0] level;

    // Error destined for the current row; entry x is read at pixel x and
    // entry x-1 is finalised (first-touch overwrite) in the same cycle.
    err_t row_err [IMAGEX];

    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    // A start-of-frame marker forces the pixel to (0,0), discarding carried error.
    assign ex        = in_sof ? '0 : x_cnt;
    assign ey        = in_sof ? '0 : y_cnt;
    assign at_origin = (ex == '0) && (ey == '0);
    assign last_col  = (ex == XW'(IMAGEX - 1));
    assign last_row  = (ey == YW'(IMAGEY - 1));
    assign mode_eff  = at_origin ? cfg_mode : mode_q;

    always_comb begin
        row_rd  = '0;
        fwd_use = '0;
        if (mode_eff && (ey != '0)) row_rd = row_err[ex];
        if (mode_eff && (ex != '0)) fwd_use = fwd_q;
        v = $signed({3'b000, in_pixel}) + fwd_use + row_rd;

        if (v[VW-1])       v_c = '0;
        else if (v > VMAX) v_c = '1;
        else               v_c = v[PIX_W-1:0];

        level = v_c[PIX_W-1 -: OUT_W];
        recon = '0;
        for (int i = 0; i < PIX_W; i++) begin
            recon[PIX_W-1-i] = level[OUT_W-1-(i % OUT_W)];
        end
        e = $signed({3'b000, v_c}) - $signed({3'b000, recon});

        p3 = (e <<< 1) + e;
        p5 = (e <<< 2) + e;
        p7 = (e <<< 3) - e;
        t_r  = p7 >>> 4;
        t_sw = p3 >>> 4;
        t_s  = p5 >>> 4;
        t_se = e >>> 4;
        if (last_col) begin
            t_r  = '0;
            t_se = '0;
        end
        if (ex == '0) t_sw = '0;
        if (last_row) begin
            t_sw = '0;
            t_s  = '0;
            t_se = '0;
        end

        acc_nxt = t_s;
        if (ex != '0) acc_nxt = se_prev + t_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_level <= '0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
            sync_err  <= 1'b0;
            x_cnt     <= '0;
            y_cnt     <= '0;
            mode_q    <= 1'b0;
            fwd_q     <= '0;
            se_prev   <= '0;
            acc_prev  <= '0;
        end else begin
            sync_err <= accept && in_sof && ((x_cnt != '0) || (y_cnt != '0));
            if (accept) begin
                out_valid <= 1'b1;
                out_level <= level;
                out_eol   <= last_col;
                out_eof   <= last_col && last_row;
                x_cnt     <= last_col ? '0 : ex + XW'(1);
                if (last_col) y_cnt <= last_row ? '0 : ey + YW'(1);
                else          y_cnt <= ey;
                if (at_origin) mode_q <= cfg_mode;
                fwd_q    <= t_r;
                se_prev  <= t_se;
                acc_prev <= acc_nxt;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            if (ex != '0) row_err[ex - XW'(1)] <= acc_prev + t_sw;
            if (last_col) row_err[ex] <= se_prev + t_s;
        end
    end
endmodule
